// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner: column drive, row synchroniser, per-frame
// debounce FSM and keymap producing one dig/op/bksp strobe per accepted press.
module keypad_scanner #(
    parameter int unsigned SCAN_DIV = 1000,
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic       key_dig,
    output logic       key_op,
    output logic       key_bksp,
    output logic [3:0] key_value,
    output logic       key_held
);

    localparam int unsigned DW_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned CNT_W = $clog2(DEBOUNCE + 1);
    localparam bit          ONE_SHOT = (DEBOUNCE == 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DEB     = 2'd1,
        S_PRESSED = 2'd2
    } state_e;

    logic [3:0]       row_s1_q, row_s2_q;
    logic [DW_W-1:0]  dwell_q;
    logic [1:0]       col_q;
    logic [3:0]       col_out_q;
    logic [1:0]       frm_cnt_q;
    logic [3:0]       frm_idx_q;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       cand_q, cand_d;
    logic             dig_q, dig_d, op_q, op_d, bksp_q, bksp_d, held_q, held_d;
    logic [3:0]       value_q, value_d;

    logic             dwell_last_c, frame_end_c, accept_c;
    logic [1:0]       smp_cnt_c, tot_cnt_c;
    logic [3:0]       smp_idx_c, tot_idx_c, code_c;
    logic [2:0]       tot_sum_c;
    logic             single_c, none_c;

    function automatic logic [3:0] keymap(input logic [3:0] idx);
        case (idx)
            4'd0:    keymap = 4'd1;
            4'd1:    keymap = 4'd2;
            4'd2:    keymap = 4'd3;
            4'd3:    keymap = 4'hA;
            4'd4:    keymap = 4'd4;
            4'd5:    keymap = 4'd5;
            4'd6:    keymap = 4'd6;
            4'd7:    keymap = 4'hB;
            4'd8:    keymap = 4'd7;
            4'd9:    keymap = 4'd8;
            4'd10:   keymap = 4'd9;
            4'd11:   keymap = 4'hC;
            4'd12:   keymap = 4'hF;
            4'd13:   keymap = 4'd0;
            4'd14:   keymap = 4'hE;
            default: keymap = 4'hD;
        endcase
    endfunction

    // Two-flop synchroniser for the asynchronous row returns
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            row_s1_q <= 4'hF;
            row_s2_q <= 4'hF;
        end else begin
            row_s1_q <= row_in;
            row_s2_q <= row_s1_q;
        end
    end

    assign dwell_last_c = (dwell_q == DW_W'(SCAN_DIV - 1));
    assign frame_end_c  = dwell_last_c && (col_q == 2'd3);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            dwell_q   <= '0;
            col_q     <= 2'd0;
            col_out_q <= 4'b1110;
        end else if (dwell_last_c) begin
            dwell_q   <= '0;
            col_q     <= col_q + 2'd1;
            col_out_q <= {col_out_q[2:0], col_out_q[3]};
        end else begin
            dwell_q   <= dwell_q + DW_W'(1);
        end
    end

    // Low-row count (saturating at 2) and key index for the current column sample
    always_comb begin
        smp_cnt_c = 2'd0;
        smp_idx_c = 4'd0;
        for (int r = 0; r < 4; r++) begin
            if (!row_s2_q[r]) begin
                if (smp_cnt_c != 2'd2) smp_cnt_c = smp_cnt_c + 2'd1;
                smp_idx_c = {2'(r), col_q};
            end
        end
    end

    assign tot_sum_c = 3'(frm_cnt_q) + 3'(smp_cnt_c);
    assign tot_cnt_c = (tot_sum_c >= 3'd2) ? 2'd2 : tot_sum_c[1:0];
    assign tot_idx_c = (smp_cnt_c != 2'd0) ? smp_idx_c : frm_idx_q;
    assign single_c  = (tot_cnt_c == 2'd1);
    assign none_c    = (tot_cnt_c == 2'd0);
    assign code_c    = keymap(tot_idx_c);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            frm_cnt_q <= 2'd0;
            frm_idx_q <= 4'd0;
        end else if (frame_end_c) begin
            frm_cnt_q <= 2'd0;
            frm_idx_q <= 4'd0;
        end else if (dwell_last_c) begin
            frm_cnt_q <= tot_cnt_c;
            frm_idx_q <= tot_idx_c;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            cand_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cand_q  <= cand_d;
        end
    end

    // Next state: one decision per frame end; cnt_q doubles as the release counter
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cand_d   = cand_q;
        accept_c = 1'b0;
        if (frame_end_c) begin
            case (state_q)
                S_IDLE: begin
                    if (single_c) begin
                        cand_d = tot_idx_c;
                        if (ONE_SHOT) begin
                            accept_c = 1'b1;
                            state_d  = S_PRESSED;
                            cnt_d    = '0;
                        end else begin
                            cnt_d   = CNT_W'(1);
                            state_d = S_DEB;
                        end
                    end
                end
                S_DEB: begin
                    if (single_c && (tot_idx_c == cand_q)) begin
                        if (cnt_q + CNT_W'(1) == CNT_W'(DEBOUNCE)) begin
                            accept_c = 1'b1;
                            state_d  = S_PRESSED;
                            cnt_d    = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else if (single_c) begin
                        cand_d = tot_idx_c;
                        cnt_d  = CNT_W'(1);
                    end else begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end
                end
                S_PRESSED: begin
                    if (!none_c) begin
                        cnt_d = '0;
                    end else if (cnt_q + CNT_W'(1) == CNT_W'(DEBOUNCE)) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Output decode: backspace raises dig as well so the control block sees it as an entry
    always_comb begin
        dig_d   = 1'b0;
        op_d    = 1'b0;
        bksp_d  = 1'b0;
        value_d = value_q;
        held_d  = (state_d == S_PRESSED);
        if (accept_c) begin
            value_d = code_c;
            if (code_c == 4'hF) begin
                bksp_d = 1'b1;
                dig_d  = 1'b1;
            end else if (code_c >= 4'hA) begin
                op_d = 1'b1;
            end else begin
                dig_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            dig_q   <= 1'b0;
            op_q    <= 1'b0;
            bksp_q  <= 1'b0;
            held_q  <= 1'b0;
            value_q <= 4'd0;
        end else begin
            dig_q   <= dig_d;
            op_q    <= op_d;
            bksp_q  <= bksp_d;
            held_q  <= held_d;
            value_q <= value_d;
        end
    end

    assign col_out   = col_out_q;
    assign key_dig   = dig_q;
    assign key_op    = op_q;
    assign key_bksp  = bksp_q;
    assign key_value = value_q;
    assign key_held  = held_q;

endmodule
